// File: rtl/pc_sequencer_if.sv
// Decode-to-sequencer instruction handshake: one decoded control word per valid/ready transfer.
// The decode side drives the master modport and the program-counter unit takes the slave modport.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic              is_branch;
    logic [3:0]        cond;
    logic              imm_valid;
    logic [ADDR_W-1:0] target;
    logic              is_call;
    logic              is_ret;

    modport master (
        output instr_valid, is_branch, cond, imm_valid, target, is_call, is_ret,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, is_branch, cond, imm_valid, target, is_call, is_ret,
        output instr_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with branch-condition evaluation and a circular return-address stack.
// Latency: pc, fetch pair and RAS update one cycle after accept; fetch outputs are combinational from pc.
// Backpressure: instr_ready = ~stall, and a stall freezes all state. Optional PC_SEQUENCER_STATS_EN adds taken_cnt.
module pc_sequencer #(
    parameter int              ADDR_W    = 16,
    parameter int              RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    pc_sequencer_if.slave                  instr,
    input  logic                           stall,
    input  logic                           flag_z,
    input  logic                           flag_s,
    input  logic                           flag_c,
    input  logic                           flag_v,
    input  logic                           busy,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W-1:0]              fetch_addr0,
    output logic [ADDR_W-1:0]              fetch_addr1,
    output logic                           redirect,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf,
    output logic [31:0]                    taken_cnt
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]     ras_sp;
    logic              accept;
    logic              taken;
    logic              ras_empty;
    logic              ras_full;
    logic              do_pop;
    logic              do_push;
    logic              take_br;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] ras_top;

    assign instr.instr_ready = ~stall;
    assign accept            = instr.instr_valid & ~stall;
    assign seq               = pc + ADDR_W'(1) + ADDR_W'(instr.imm_valid);
    assign fetch_addr0       = pc;
    assign fetch_addr1       = pc + ADDR_W'(1);

    always_comb begin
        taken = 1'b0;
        unique case (instr.cond)
            4'b0000: taken = 1'b1;
            4'b0001: taken = flag_z;
            4'b0010: taken = ~flag_z;
            4'b0011: taken = ~(flag_s ^ flag_v);
            4'b0100: taken = flag_z & (flag_s ^ flag_v);
            4'b0101: taken = ~flag_z & ~(flag_s ^ flag_v);
            4'b0110: taken = flag_s ^ flag_v;
            4'b0111: taken = flag_v;
            4'b1000: taken = busy;
            4'b1001: taken = flag_s;
            4'b1010: taken = ~flag_s;
            4'b1011: taken = ~flag_c;
            4'b1100: taken = flag_z | flag_c;
            4'b1101: taken = ~(flag_z | flag_c);
            4'b1110: taken = flag_c;
            4'b1111: taken = ~flag_v;
            default: taken = 1'b0;
        endcase
    end

    // ras_sp points at the next free slot; a push while full overwrites the oldest entry.
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign ras_top   = ras_mem[ras_sp - PW'(1)];
    assign do_pop    = accept & instr.is_ret & ~ras_empty;
    assign take_br   = accept & ~instr.is_ret & instr.is_branch & taken;
    assign do_push   = take_br & instr.is_call;

    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_sp] <= seq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            redirect  <= 1'b0;
            ras_sp    <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            redirect <= take_br | do_pop;
            if (accept) begin
                if (do_pop) begin
                    pc        <= ras_top;
                    ras_sp    <= ras_sp - PW'(1);
                    ras_count <= ras_count - CW'(1);
                end else if (take_br) begin
                    pc <= instr.target;
                end else begin
                    pc <= seq;
                end
                if (instr.is_ret && ras_empty) begin
                    ras_unf <= 1'b1;
                end
                if (do_push) begin
                    ras_sp <= ras_sp + PW'(1);
                    if (ras_full) begin
                        ras_ovf <= 1'b1;
                    end else begin
                        ras_count <= ras_count + CW'(1);
                    end
                end
            end
        end
    end

`ifdef PC_SEQUENCER_STATS_EN
    logic [31:0] taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= '0;
        end else if ((take_br || do_pop) && (taken_q != 32'hFFFF_FFFF)) begin
            taken_q <= taken_q + 32'd1;
        end
    end

    assign taken_cnt = taken_q;
`else
    assign taken_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (ADDR_W=16, RAS_DEPTH=8, RESET_PC=0).
// Inputs are driven 1ns after the rising edge; outputs are checked at that same point after each accept.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flag_z = 1'b0, flag_s = 1'b0, flag_c = 1'b0, flag_v = 1'b0, busy = 1'b0;
    logic [15:0] pc, fetch_addr0, fetch_addr1;
    logic        redirect, ras_ovf, ras_unf;
    logic [3:0]  ras_count;
    logic [31:0] taken_cnt;
    int          n_cmp = 0;
    int          n_fail = 0;

    pc_sequencer_if #(.ADDR_W(16)) bus ();

    pc_sequencer #(.ADDR_W(16), .RAS_DEPTH(8), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .instr(bus), .stall(stall),
        .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c), .flag_v(flag_v), .busy(busy),
        .pc(pc), .fetch_addr0(fetch_addr0), .fetch_addr1(fetch_addr1), .redirect(redirect),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // {cond, z, s, c, v, expected taken}
    logic [8:0] cv [0:13] = '{
        {4'b0000, 4'b0000, 1'b1}, {4'b0001, 4'b1000, 1'b1}, {4'b0010, 4'b1000, 1'b0},
        {4'b0011, 4'b0100, 1'b0}, {4'b0100, 4'b1100, 1'b1}, {4'b0110, 4'b0001, 1'b1},
        {4'b0111, 4'b0000, 1'b0}, {4'b1001, 4'b0100, 1'b1}, {4'b1010, 4'b0100, 1'b0},
        {4'b1011, 4'b0000, 1'b1}, {4'b1100, 4'b0000, 1'b0}, {4'b1101, 4'b0000, 1'b1},
        {4'b1110, 4'b0010, 1'b1}, {4'b1111, 4'b0001, 1'b0}
    };

    task automatic clear_inputs();
        bus.instr_valid = 1'b0; bus.is_branch = 1'b0; bus.cond = 4'b0000; bus.imm_valid = 1'b0;
        bus.target = 16'h0000; bus.is_call = 1'b0; bus.is_ret = 1'b0;
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic go(input logic br, input logic [3:0] cnd, input logic imm,
                      input logic [15:0] tgt, input logic call, input logic ret);
        bus.instr_valid = 1'b1; bus.is_branch = br; bus.cond = cnd; bus.imm_valid = imm;
        bus.target = tgt; bus.is_call = call; bus.is_ret = ret;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic set_pc(input logic [15:0] a);
        go(1'b1, 4'b0000, 1'b0, a, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        n_cmp++; if (ras_count !== 4'd0) begin n_fail++; $display("FAIL reset_ras_count got=%0d exp=0", ras_count); end
        n_cmp++; if ({ras_ovf, ras_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_sticky got=%b%b exp=00", ras_ovf, ras_unf); end
        n_cmp++; if (taken_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_taken_cnt got=%0d exp=0", taken_cnt); end
        n_cmp++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_pc [3] = '{16'h0001, 16'h0003, 16'h0004};
        logic [2:0]  imms = 3'b010;
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 4'b0000, imms[2-i], 16'hDEAD, 1'b0, 1'b0);
            n_cmp++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
            n_cmp++; if (fetch_addr1 !== exp_pc[i] + 16'd1) begin n_fail++; $display("FAIL seq_fa1_%0d got=%h exp=%h", i, fetch_addr1, exp_pc[i] + 16'd1); end
            n_cmp++; if (fetch_addr0 !== exp_pc[i]) begin n_fail++; $display("FAIL seq_fa0_%0d got=%h exp=%h", i, fetch_addr0, exp_pc[i]); end
            n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL seq_redirect%0d got=%b exp=0", i, redirect); end
        end
    endtask

    task automatic test_branch_cond();
        logic [15:0] exp_pc;
        flag_z = 1'b0; flag_s = 1'b1; flag_c = 1'b0; flag_v = 1'b1;
        set_pc(16'h0010);
        go(1'b1, 4'b0101, 1'b0, 16'h0200, 1'b0, 1'b0);
        n_cmp++; if (pc !== 16'h0200) begin n_fail++; $display("FAIL br0101_taken_pc got=%h exp=0200", pc); end
        n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL br0101_redirect got=%b exp=1", redirect); end
        @(posedge clk); #1;
        n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL br_redirect_pulse got=%b exp=0", redirect); end
        set_pc(16'h0010);
        flag_z = 1'b1;
        go(1'b1, 4'b0101, 1'b0, 16'h0200, 1'b0, 1'b0);
        n_cmp++; if (pc !== 16'h0011) begin n_fail++; $display("FAIL br0101_not_taken_pc got=%h exp=0011", pc); end
        n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL br0101_nt_redirect got=%b exp=0", redirect); end
        // Back-to-back accepts across the condition table.
        set_pc(16'h0500);
        exp_pc = 16'h0500;
        for (int i = 0; i < 14; i++) begin
            {flag_z, flag_s, flag_c, flag_v} = cv[i][4:1];
            go(1'b1, cv[i][8:5], 1'b0, 16'h0300, 1'b0, 1'b0);
            exp_pc = cv[i][0] ? 16'h0300 : exp_pc + 16'd1;
            n_cmp++; if (pc !== exp_pc || redirect !== cv[i][0])
                begin n_fail++; $display("FAIL cond%b pc=%h redir=%b exp pc=%h redir=%b", cv[i][8:5], pc, redirect, exp_pc, cv[i][0]); end
        end
    endtask

    task automatic test_busy();
        flag_z = 1'b0; flag_s = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
        set_pc(16'h0700);
        busy = 1'b1;
        go(1'b1, 4'b1000, 1'b0, 16'h0800, 1'b0, 1'b0);
        n_cmp++; if (pc !== 16'h0800) begin n_fail++; $display("FAIL busy1_pc got=%h exp=0800", pc); end
        busy = 1'b0;
        go(1'b1, 4'b1000, 1'b0, 16'h0900, 1'b0, 1'b0);
        n_cmp++; if (pc !== 16'h0801) begin n_fail++; $display("FAIL busy0_pc got=%h exp=0801", pc); end
    endtask

    task automatic test_call_ret();
        set_pc(16'h0040);
        go(1'b1, 4'b0000, 1'b1, 16'h0100, 1'b1, 1'b0);
        n_cmp++; if (pc !== 16'h0100) begin n_fail++; $display("FAIL call_pc got=%h exp=0100", pc); end
        n_cmp++; if (ras_count !== 4'd1) begin n_fail++; $display("FAIL call_ras_count got=%0d exp=1", ras_count); end
        go(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b1, 1'b1);
        n_cmp++; if (pc !== 16'h0042) begin n_fail++; $display("FAIL ret_pc got=%h exp=0042", pc); end
        n_cmp++; if (ras_count !== 4'd0) begin n_fail++; $display("FAIL ret_ras_count got=%0d exp=0", ras_count); end
        n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL ret_redirect got=%b exp=1", redirect); end
        n_cmp++; if (ras_unf !== 1'b0) begin n_fail++; $display("FAIL ret_unf_early got=%b exp=0", ras_unf); end
        go(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        n_cmp++; if (pc !== 16'h0043) begin n_fail++; $display("FAIL ret_empty_pc got=%h exp=0043", pc); end
        n_cmp++; if (ras_unf !== 1'b1) begin n_fail++; $display("FAIL ret_empty_unf got=%b exp=1", ras_unf); end
        n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL ret_empty_redirect got=%b exp=0", redirect); end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] pushed [9];
        logic [15:0] cur;
        set_pc(16'h1000);
        cur = 16'h1000;
        for (int i = 0; i < 9; i++) begin
            pushed[i] = cur + 16'd1;
            go(1'b1, 4'b0000, 1'b0, 16'h2000 + 16'(i * 16), 1'b1, 1'b0);
            cur = 16'h2000 + 16'(i * 16);
        end
        n_cmp++; if (ras_count !== 4'd8) begin n_fail++; $display("FAIL ovf_ras_count got=%0d exp=8", ras_count); end
        n_cmp++; if (ras_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", ras_ovf); end
        for (int i = 8; i >= 1; i--) begin
            go(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1);
            n_cmp++; if (pc !== pushed[i]) begin n_fail++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, pc, pushed[i]); end
        end
        n_cmp++; if (ras_count !== 4'd0) begin n_fail++; $display("FAIL ovf_drained got=%0d exp=0", ras_count); end
    endtask

    task automatic test_stall_wrap();
        set_pc(16'hFFFF);
        bus.instr_valid = 1'b1; bus.imm_valid = 1'b1; stall = 1'b1;
        #1;
        n_cmp++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", bus.instr_ready); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=FFFF", i, pc); end
        end
        n_cmp++; if (fetch_addr1 !== 16'h0000) begin n_fail++; $display("FAIL wrap_fa1 got=%h exp=0000", fetch_addr1); end
        stall = 1'b0;
        @(posedge clk); #1;
        clear_inputs();
        n_cmp++; if (pc !== 16'h0001) begin n_fail++; $display("FAIL stall_release_pc got=%h exp=0001", pc); end
        n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL stall_release_redirect got=%b exp=0", redirect); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_cnt;
`ifdef PC_SEQUENCER_STATS_EN
        exp_cnt = 32'd4;
`else
        exp_cnt = 32'd0;
`endif
        rst_n = 1'b0;
        #2;
        n_cmp++; if ({ras_ovf, ras_unf} !== 2'b00) begin n_fail++; $display("FAIL stats_sticky_cleared got=%b%b exp=00", ras_ovf, ras_unf); end
        rst_n = 1'b1;
        flag_z = 1'b1; flag_s = 1'b0; flag_c = 1'b0; flag_v = 1'b0;
        set_pc(16'h0010);
        go(1'b1, 4'b0010, 1'b0, 16'h0AAA, 1'b0, 1'b0);
        set_pc(16'h0020);
        go(1'b1, 4'b0000, 1'b0, 16'h0030, 1'b1, 1'b0);
        go(1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        n_cmp++; if (pc !== 16'h0021) begin n_fail++; $display("FAIL stats_ret_pc got=%h exp=0021", pc); end
        n_cmp++; if (taken_cnt !== exp_cnt) begin n_fail++; $display("FAIL stats_taken_cnt got=%0d exp=%0d", taken_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_cond();
        test_busy();
        test_call_ret();
        test_ras_overflow();
        test_stall_wrap();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit: holds the current instruction pointer and evaluates the 16 branch conditions against the CSR flags.
- Selects the next fetch pair (pc, pc+1) on each accepted instruction.
- Generalised from the combinational next-pointer logic: parametrised address width, a return-address stack (RAS) for call/return, a valid/ready handshake with stall, and real evaluation of the busy condition.
- Sits between decode and fetch; drives the fetch address pair.

Parameters:
ADDR_W, 16, instruction-pointer width in bits (8..32)
RAS_DEPTH, 8, return-address stack entries (power of 2, >=2)
RESET_PC, 0, pc value after reset

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  decoded instruction presented
instr_ready  out  1  unit can accept; = ~stall
stall  in  1  backend stall; holds pc
is_branch  in  1  instruction is a branch (opcode[31:28]==4'b010x)
cond  in  4  condition code {instr[28], instr[26:24]}
imm_valid  in  1  instruction carries an immediate word
target  in  ADDR_W  branch target (src2)
is_call  in  1  taken branch also pushes return address
is_ret  in  1  pop RAS and jump to popped address
flag_z, flag_s, flag_c, flag_v  in  1 each  CSR Zero/Sign/Carry/Overflow
busy  in  1  external unit busy (condition 1000)
pc  out  ADDR_W  current instruction pointer (registered)
fetch_addr0  out  ADDR_W  = pc
fetch_addr1  out  ADDR_W  = pc+1 mod 2^ADDR_W
redirect  out  1  one-cycle pulse: pc changed non-sequentially last accept
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_ovf  out  1  sticky: push while full
ras_unf  out  1  sticky: pop while empty
taken_cnt  out  32  taken-branch counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC, redirect=0, ras_count=0, ras_ovf=0, ras_unf=0, taken_cnt=0.
  - RAS storage contents are don't-care.
- Accept: accept = instr_valid & instr_ready. With no accept, all state holds and redirect=0.
- Condition taken, by cond:
  - 0000 always; 0001 Z; 0010 ~Z; 0011 S xnor V.
  - 0100 Z & (S^V); 0101 ~Z & (S xnor V); 0110 S^V; 0111 V.
  - 1000 busy; 1001 S; 1010 ~S; 1011 ~C.
  - 1100 Z|C; 1101 ~(Z|C); 1110 C; 1111 ~V.
- Sequential next: seq = pc + 1 + imm_valid, mod 2^ADDR_W (wraps, no flag).
- Next-pc priority on accept:
  1. is_ret: pc <= RAS top, pop. If RAS empty: pc <= seq, ras_unf <= 1, no redirect.
  2. is_branch & taken: pc <= target.
  3. Otherwise: pc <= seq.
- redirect asserts the cycle after an accept that took branch 1 (non-empty) or 2.
- Call: is_branch & taken & is_call pushes seq.
  - Not taken: no push.
  - Full: overwrite oldest entry (circular), ras_count stays RAS_DEPTH, ras_ovf <= 1.
- is_ret together with is_call: ret wins, no push, ras_unf unaffected unless empty.
- Latency: pc, fetch_addr0/1 and RAS update one cycle after accept. fetch outputs are combinational from the pc register.
- Stall: instr_ready=0 the same cycle. Inputs are ignored and state frozen.
- Sticky flags clear only on reset.
- Reset mid-stall or mid-push: async reset wins immediately. No partial RAS update.

Optional Feature:
- PC_SEQUENCER_STATS_EN defined:
  - taken_cnt increments on each accept that redirects (taken branch or successful ret).
  - Saturates at 32'hFFFF_FFFF.
- Undefined: taken_cnt tied to 0 and no counter flops synthesised. Port list unchanged.

Test Plan:
- Reset, then accept 3 non-branch instrs with imm_valid=0,1,0 -> pc 0,1,3,4; fetch_addr1 = pc+1; redirect=0.
- pc=0x0010, is_branch, cond=0101, Z=0, S=1, V=1 -> pc=target 0x0200, redirect pulse 1 cycle; same with Z=1 -> pc=0x0011.
- cond=1000 with busy=1 -> taken; busy=0 -> pc advances sequentially.
- pc=0x0040 call (imm_valid=1) to 0x0100, then ret -> pc=0x0100 then 0x0042, ras_count 1->0; ret on empty -> pc seq, ras_unf=1.
- RAS_DEPTH=8: 9 nested calls -> ras_ovf=1, ras_count=8; 8 rets return the 8 newest addresses.
- pc=0xFFFF, imm_valid=1, stall asserted 2 cycles then released -> pc holds 0xFFFF during stall, then 0x0001.
